sync_fifo_mem: RTL and testbench
================================

SYNC_FIFO_MEM -- requirements
Module: sync_fifo_mem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 3, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL have parameter AF_LEVEL, default 6, meaning the count at or above which almost_full asserts.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, meaning reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port clr, input, 1 bit, meaning synchronous flush.
REQ-007 The block SHALL have port wr_en, input, 1 bit, meaning write request.
REQ-008 The block SHALL have port din, input, DATA_W bits, meaning write data.
REQ-009 The block SHALL have port rd_en, input, 1 bit, meaning read request.
REQ-010 The block SHALL have port dout, output, DATA_W bits, meaning registered read data.
REQ-011 The block SHALL have port empty, output, 1 bit, meaning count == 0.
REQ-012 The block SHALL have port full, output, 1 bit, meaning count == DEPTH.
REQ-013 The block SHALL have port almost_full, output, 1 bit, meaning count >= AF_LEVEL.
REQ-014 The block SHALL have port count, output, ADDR_W+1 bits, meaning current occupancy 0..DEPTH.

Function
REQ-015 A write SHALL be accepted iff wr_en=1, full=0 and clr=0; din is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-016 A read SHALL be accepted iff rd_en=1, empty=0 and clr=0; the word at rd_ptr appears on dout at the next rising edge (latency 1), and rd_ptr increments modulo DEPTH.
REQ-017 dout SHALL hold its last value in every cycle without an accepted read.
REQ-018 When a write and a read are accepted in the same cycle, count SHALL remain unchanged.
REQ-019 A write SHALL be rejected when full=1, even with a simultaneous read; there is no write-through.
REQ-020 A read SHALL be rejected when empty=1, even with a simultaneous write; there is no bypass.
REQ-021 Rejected requests SHALL leave pointers, count and memory contents unchanged.
REQ-022 empty, full and almost_full SHALL be derived combinationally from registered count; they update the cycle after the accepting edge.
REQ-023 clr=1 SHALL zero wr_ptr, rd_ptr and count at the next edge, override wr_en and rd_en, and leave dout and memory contents unchanged.
REQ-024 Pointer wrap from DEPTH-1 to 0 SHALL preserve FIFO ordering.

Reset
REQ-025 rst_n=0 SHALL immediately force wr_ptr=0, rd_ptr=0, count=0 and dout=0, giving empty=1, full=0 and almost_full=0.
REQ-026 Memory array contents SHALL NOT be reset.
REQ-027 Reset asserted mid-operation SHALL discard all stored entries; the first accepted read after reset returns the first word written after reset.

Configuration
REQ-028 With FIFO_ERR_FLAGS_EN defined, the block SHALL add outputs overflow and underflow (1 bit each, reset 0), which are sticky: overflow sets on wr_en while full, underflow sets on rd_en while empty, and both clear only on rst_n or clr.
REQ-029 Without FIFO_ERR_FLAGS_EN, these ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package fifo_pkg SHALL hold the default DATA_W, ADDR_W and AF_LEVEL constants and a function computing DEPTH from ADDR_W.
REQ-031 Storage SHALL be a sub-module dp_ram: one synchronous write port, one synchronous registered read port, and separate wr/rd addresses, parametrised by DATA_W and ADDR_W.
REQ-032 Pointer, count and flag logic SHALL reside in sync_fifo_mem.

Verification
REQ-033 Fill scenario: after reset, write din=0..7 on consecutive cycles -> full=1 after the 8th write; almost_full=1 from count=6; a 9th write is rejected and count stays 8.
REQ-034 Drain scenario: from full, read 8 times -> dout=0,1,..,7, each one cycle after its read; empty=1 afterwards; a further read leaves dout=7.
REQ-035 Simultaneous scenario: at count=3, wr_en=rd_en=1 for 5 cycles -> count stays 3 and output order is preserved across pointer wrap.
REQ-036 Reset/clear scenario: write 4 words, pulse clr -> count=0 and empty=1; write A, then read -> dout=A; repeat with rst_n low mid-burst -> dout=0 and empty=1 immediately.
REQ-037 Error-flag scenario (FIFO_ERR_FLAGS_EN): read while empty -> underflow=1 and held; write 9 words -> overflow=1; clr -> both flags 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults for the synchronous FIFO: word width, address width,
// almost-full threshold and the depth helper.
package fifo_pkg;

  localparam int FIFO_DATA_W   = 4;
  localparam int FIFO_ADDR_W   = 3;
  localparam int FIFO_AF_LEVEL = 6;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port storage: synchronous write, registered read with enable.
// The array itself is never reset; only the read register clears on rst_n.
module dp_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register holds its value between accepted reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo_mem.sv
// Single-clock FIFO: pointers, occupancy count and status flags around dp_ram.
// Optional sticky overflow/underflow outputs are built when FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W   = FIFO_DATA_W,
  parameter int ADDR_W   = FIFO_ADDR_W,
  parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int              DEPTH    = fifo_depth(ADDR_W);
  localparam logic [ADDR_W:0] C_DEPTH  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] C_AF_LVL = AF_LEVEL[ADDR_W:0];

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_wr_acc;
  logic              w_rd_acc;

  // Flush wins over both requests; no write-through when full, no bypass when empty.
  assign w_wr_acc = wr_en & ~full  & ~clr;
  assign w_rd_acc = rd_en & ~empty & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign count       = r_count;
  assign empty       = (r_count == '0);
  assign full        = (r_count == C_DEPTH);
  assign almost_full = (r_count >= C_AF_LVL);

  dp_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_en  (w_wr_acc),
    .i_wr_addr(r_wr_ptr),
    .i_wr_data(din),
    .i_rd_en  (w_rd_acc),
    .i_rd_addr(r_rd_ptr),
    .o_rd_data(dout)
  );

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && full)  r_overflow  <= 1'b1;
      if (rd_en && empty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo_mem.sv
// Directed bench for sync_fifo_mem: fill, drain, wrap, flush and reset cases.
// Flag checks are compiled in only when FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo_mem;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       wr_en;
  logic [3:0] din;
  logic       rd_en;
  logic [3:0] dout;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [3:0] count;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  int n_checks = 0;
  int n_errors = 0;

  sync_fifo_mem #(
    .DATA_W  (4),
    .ADDR_W  (3),
    .AF_LEVEL(6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .wr_en      (wr_en),
    .din        (din),
    .rd_en      (rd_en),
    .dout       (dout),
    .empty      (empty),
    .full       (full),
    .almost_full(almost_full),
    .count      (count)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow   (overflow),
    .underflow  (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d);
    wr_en = 1'b1; din = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    #1;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full",  int'(full), 0);
    check("rst_af",    int'(almost_full), 0);
    check("rst_dout",  int'(dout), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // fill with 0..7
    for (int i = 0; i < 8; i++) begin
      push(4'(i));
      check("fill_count", int'(count), i + 1);
      check("fill_af",    int'(almost_full), (i + 1 >= 6) ? 1 : 0);
      check("fill_full",  int'(full), (i == 7) ? 1 : 0);
    end
    push(4'd9);
    check("ovf_count", int'(count), 8);
    check("ovf_full",  int'(full), 1);

    // drain: 0..7 in order
    for (int i = 0; i < 8; i++) begin
      pop();
      check("drain_dout",  int'(dout), i);
      check("drain_count", int'(count), 7 - i);
    end
    check("drain_empty", int'(empty), 1);
    pop();
    check("udf_dout",  int'(dout), 7);
    check("udf_count", int'(count), 0);

    // advance both pointers to 5
    for (int i = 0; i < 5; i++) push(4'(i));
    for (int i = 0; i < 5; i++) pop();
    check("adv_dout",  int'(dout), 4);
    check("adv_empty", int'(empty), 1);

    // count=3 across write-pointer wrap, then simultaneous across read-pointer wrap
    push(4'hA); push(4'hB); push(4'hC);
    check("sim_pre_count", int'(count), 3);
    begin
      logic [3:0] exp_q [5];
      exp_q[0] = 4'hA; exp_q[1] = 4'hB; exp_q[2] = 4'hC; exp_q[3] = 4'd1; exp_q[4] = 4'd2;
      for (int i = 0; i < 5; i++) begin
        wr_en = 1'b1; rd_en = 1'b1; din = 4'(i + 1);
        tick();
        check("sim_count", int'(count), 3);
        check("sim_dout",  int'(dout), int'(exp_q[i]));
      end
      wr_en = 1'b0; rd_en = 1'b0;
    end
    pop(); check("sim_tail0", int'(dout), 3);
    pop(); check("sim_tail1", int'(dout), 4);
    pop(); check("sim_tail2", int'(dout), 5);
    check("sim_empty", int'(empty), 1);

    // clear: drops contents, keeps dout
    push(4'd6); push(4'd7); push(4'd8); push(4'd9);
    check("clr_pre_count", int'(count), 4);
    clr = 1'b1; wr_en = 1'b1; din = 4'hF;
    tick();
    clr = 1'b0; wr_en = 1'b0;
    check("clr_count", int'(count), 0);
    check("clr_empty", int'(empty), 1);
    check("clr_dout",  int'(dout), 5);
    push(4'hD);
    pop();
    check("clr_first", int'(dout), 13);

    // asynchronous reset mid-burst
    push(4'd1); push(4'd2);
    wr_en = 1'b1; din = 4'd3;
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_dout",  int'(dout), 0);
    check("arst_empty", int'(empty), 1);
    check("arst_count", int'(count), 0);
    wr_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    push(4'hE);
    pop();
    check("arst_first", int'(dout), 14);

    // read while empty with a write: no bypass
    wr_en = 1'b1; rd_en = 1'b1; din = 4'd3;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("nobyp_count", int'(count), 1);
    check("nobyp_dout",  int'(dout), 14);
    pop();
    check("nobyp_read",  int'(dout), 3);

`ifdef FIFO_ERR_FLAGS_EN
    clr = 1'b1; tick(); clr = 1'b0;
    check("flg_clr0_udf", int'(underflow), 0);
    pop();
    check("flg_udf_set",  int'(underflow), 1);
    tick();
    check("flg_udf_hold", int'(underflow), 1);
    for (int i = 0; i < 9; i++) push(4'(i));
    check("flg_ovf_set",  int'(overflow), 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("flg_clr_ovf",  int'(overflow), 0);
    check("flg_clr_udf",  int'(underflow), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
